// File: rtl/spec_evt_pkg.sv
// Shared types and sizing helpers for the event-burst generator and the
// downstream event counters that must wrap at the same index.
package spec_evt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } evt_gen_state_t;

    // Counters size their index with this so both ends agree on the wrap point.
    function automatic int evt_idx_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/spec_period_timer.sv
// Reloadable down-counter that paces events: expires once every PERIOD
// enabled cycles, reloading itself on expiry.
module spec_period_timer #(
    parameter  int PERIOD = 4,
    localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic load_in,
    input  logic enable_in,
    output logic expire_out
);

    localparam logic [TW-1:0] LP_RELOAD = TW'(PERIOD - 1);

    logic [TW-1:0] r_count;

    assign expire_out = enable_in && (r_count == '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_count <= '0;
        end else if (load_in) begin
            r_count <= LP_RELOAD;
        end else if (enable_in) begin
            if (r_count == '0) begin
                r_count <= LP_RELOAD;
            end else begin
                r_count <= r_count - TW'(1);
            end
        end
    end

endmodule

// File: rtl/spec_evt_generator.sv
// Event-burst generator: on start, emits MAX_COUNT single-cycle strobes spaced
// PERIOD cycles apart, tagged with index, almost-last and last flags.
module spec_evt_generator
    import spec_evt_pkg::*;
#(
    parameter  int MAX_COUNT = 6,
    parameter  int PERIOD    = 4,
    localparam int IW        = evt_idx_width(MAX_COUNT)
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           start_in,
    input  logic           abort_in,
    output logic           evt_out,
    output logic [IW-1:0]  index_out,
    output logic           almost_out,
    output logic           last_out,
    output logic           busy_out,
    output logic           done_out,
    output evt_gen_state_t dbg_state_out
);

    localparam logic [IW-1:0] LP_LAST   = IW'(MAX_COUNT - 1);
    localparam logic [IW-1:0] LP_ALMOST = IW'(MAX_COUNT - 2);

    // start_in is a request sampled only in IDLE (no queuing); abort_in is a
    // level sampled only in RUN and wins over an event due on the same edge.
    evt_gen_state_t r_state;
    evt_gen_state_t w_nxt_state;
    logic [IW-1:0]  r_index;
    logic           w_load;
    logic           w_fire;
    logic           w_done;
    logic           w_expire;
    logic           w_timer_en;

    logic           r_evt;
    logic [IW-1:0]  r_index_out;
    logic           r_almost;
    logic           r_last;
    logic           r_busy;
    logic           r_done;

    assign w_timer_en = (r_state == RUN);

    spec_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load_in    (w_load),
        .enable_in  (w_timer_en),
        .expire_out (w_expire)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_fire      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_in && !abort_in) begin
                    w_nxt_state = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (abort_in) begin
                    w_nxt_state = IDLE;
                end else if (w_expire) begin
                    w_fire = 1'b1;
                    if (r_index == LP_LAST) begin
                        w_nxt_state = DONE;
                    end
                end
            end
            DONE: begin
                w_nxt_state = IDLE;
                w_done      = 1'b1;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_evt       <= 1'b0;
            r_index_out <= '0;
            r_almost    <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            if (w_load) begin
                r_index <= '0;
            end else if (w_fire && (r_index != LP_LAST)) begin
                r_index <= r_index + IW'(1);
            end
            r_evt    <= w_fire;
            r_almost <= w_fire && (r_index == LP_ALMOST);
            r_last   <= w_fire && (r_index == LP_LAST);
            // Hold the last emitted index between strobes; clear on leaving RUN.
            if (w_fire) begin
                r_index_out <= r_index;
            end else if (w_nxt_state != RUN) begin
                r_index_out <= '0;
            end
            r_busy <= (w_nxt_state == RUN);
            r_done <= w_done;
        end
    end

    assign evt_out       = r_evt;
    assign index_out     = r_index_out;
    assign almost_out    = r_almost;
    assign last_out      = r_last;
    assign busy_out      = r_busy;
    assign done_out      = r_done;
    assign dbg_state_out = r_state;

endmodule

// File: tb/tb_spec_evt_generator.sv
// Bench for spec_evt_generator: two instances (6x4 and 2x1) checked every
// cycle against a burst-timeline model, plus directed literal timelines.
module tb_spec_evt_generator;
    import spec_evt_pkg::*;

    localparam int MC_A = 6;
    localparam int P_A  = 4;
    localparam int MC_B = 2;
    localparam int P_B  = 1;
    localparam int IW_A = evt_idx_width(MC_A);
    localparam int IW_B = evt_idx_width(MC_B);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;

    logic            evt_a, almost_a, last_a, busy_a, done_a;
    logic [IW_A-1:0] idx_a;
    evt_gen_state_t  dbg_a;
    logic            evt_b, almost_b, last_b, busy_b, done_b;
    logic [IW_B-1:0] idx_b;
    evt_gen_state_t  dbg_b;

    spec_evt_generator #(.MAX_COUNT(MC_A), .PERIOD(P_A)) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .abort_in(abort_a),
        .evt_out(evt_a), .index_out(idx_a), .almost_out(almost_a), .last_out(last_a),
        .busy_out(busy_a), .done_out(done_a), .dbg_state_out(dbg_a)
    );

    spec_evt_generator #(.MAX_COUNT(MC_B), .PERIOD(P_B)) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .abort_in(abort_b),
        .evt_out(evt_b), .index_out(idx_b), .almost_out(almost_b), .last_out(last_b),
        .busy_out(busy_b), .done_out(done_b), .dbg_state_out(dbg_b)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- timeline model ----------------
    // Phase = edges elapsed since the accepting edge t0, or -1 when idle.
    // Event k lands at phase (k+1)*P, done at MC*P+1, abort kills the burst.
    int pa = -1;
    int pb = -1;

    function automatic int next_phase(input int p, input int mc, input int per,
                                      input logic st, input logic ab);
        if (p < 0 || p == mc * per + 1) return (st && !ab) ? 0 : -1;
        if (p == mc * per) return mc * per + 1;
        return ab ? -1 : p + 1;
    endfunction

    function automatic logic [12:0] expect_out(input int p, input int mc, input int per);
        logic ev;
        int   idx;
        ev  = (p >= per) && (p <= mc * per) && ((p % per) == 0);
        idx = (p >= per && p <= mc * per) ? (p / per - 1) : 0;
        return {ev, 8'(idx), ev && (idx == mc - 2), ev && (idx == mc - 1),
                (p >= 0) && (p < mc * per), (p == mc * per + 1)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa <= -1;
            pb <= -1;
        end else begin
            pa <= next_phase(pa, MC_A, P_A, start_a, abort_a);
            pb <= next_phase(pb, MC_B, P_B, start_b, abort_b);
        end
    end

    // ---------------- checkers ----------------
    task automatic check_vec(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%h expected=%h (evt,idx[8],almost,last,busy,done)",
                     name, $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_q(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check_int({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got=%0d expected=%0d", name, i, got[i], exp[i]);
            end
        end
    endtask

    // Per-cycle compare against the model, both instances.
    always @(negedge clk) begin
        check_vec("model_a", {evt_a, 8'(idx_a), almost_a, last_a, busy_a, done_a},
                  expect_out(pa, MC_A, P_A));
        check_vec("model_b", {evt_b, 8'(idx_b), almost_b, last_b, busy_b, done_b},
                  expect_out(pb, MC_B, P_B));
    end

    // ---------------- scoreboard / driver ----------------
    logic [7:0] ev_q[$], ix_q[$], al_q[$], la_q[$], dn_q[$];
    logic [7:0] exp_q[$];
    int         busy_n;

    // Starts a burst on the next edge (t0) and logs, for each observed cycle
    // k (outputs after edge t0+k), where strobes, flags and done appear.
    task automatic window(input bit sel, input int n, input int start_hold, input int abort_at);
        ev_q.delete(); ix_q.delete(); al_q.delete(); la_q.delete(); dn_q.delete();
        busy_n = 0;
        if (!sel) start_a = 1'b1; else start_b = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!sel) begin
                start_a = (k < start_hold);
                abort_a = (k == abort_at);
                if (evt_a)    begin ev_q.push_back(8'(k)); ix_q.push_back(8'(idx_a)); end
                if (almost_a) al_q.push_back(8'(k));
                if (last_a)   la_q.push_back(8'(k));
                if (done_a)   dn_q.push_back(8'(k));
                if (busy_a)   busy_n++;
            end else begin
                start_b = (k < start_hold);
                abort_b = (k == abort_at);
                if (evt_b)    begin ev_q.push_back(8'(k)); ix_q.push_back(8'(idx_b)); end
                if (almost_b) al_q.push_back(8'(k));
                if (last_b)   la_q.push_back(8'(k));
                if (done_b)   dn_q.push_back(8'(k));
                if (busy_b)   busy_n++;
            end
        end
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
    endtask

    task automatic check_full_a(input string tag);
        exp_q = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24};
        check_q({tag, "_evt_t"}, ev_q, exp_q);
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        check_q({tag, "_idx"}, ix_q, exp_q);
        exp_q = '{8'd20};
        check_q({tag, "_almost_t"}, al_q, exp_q);
        exp_q = '{8'd24};
        check_q({tag, "_last_t"}, la_q, exp_q);
        exp_q = '{8'd25};
        check_q({tag, "_done_t"}, dn_q, exp_q);
        check_int({tag, "_busy_cycles"}, busy_n, 24);
    endtask

    initial begin
        int ev_n;
        int bz_n;

        // Reset state
        repeat (3) @(negedge clk);
        check_vec("reset_a", {evt_a, 8'(idx_a), almost_a, last_a, busy_a, done_a}, 13'd0);
        check_vec("reset_b", {evt_b, 8'(idx_b), almost_b, last_b, busy_b, done_b}, 13'd0);
        check_int("reset_state_a", int'(dbg_a), int'(IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain 6x4 burst
        window(1'b0, 30, 0, -1);
        check_full_a("burst_a");

        // PERIOD=1, MAX_COUNT=2
        window(1'b1, 6, 0, -1);
        exp_q = '{8'd1, 8'd2};
        check_q("burst_b_evt_t", ev_q, exp_q);
        exp_q = '{8'd0, 8'd1};
        check_q("burst_b_idx", ix_q, exp_q);
        exp_q = '{8'd1};
        check_q("burst_b_almost_t", al_q, exp_q);
        exp_q = '{8'd2};
        check_q("burst_b_last_t", la_q, exp_q);
        exp_q = '{8'd3};
        check_q("burst_b_done_t", dn_q, exp_q);
        check_int("burst_b_busy_cycles", busy_n, 2);

        // start held through the burst and into the done cycle: the burst is
        // not disturbed and the done-cycle start launches a second one.
        window(1'b0, 56, 26, -1);
        exp_q = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20, 8'd24,
                  8'd30, 8'd34, 8'd38, 8'd42, 8'd46, 8'd50};
        check_q("hold_evt_t", ev_q, exp_q);
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        check_q("hold_idx", ix_q, exp_q);
        exp_q = '{8'd25, 8'd51};
        check_q("hold_done_t", dn_q, exp_q);
        check_int("hold_busy_cycles", busy_n, 48);

        // Abort sampled on the edge where event 2 is due
        window(1'b0, 20, 0, 11);
        exp_q = '{8'd4, 8'd8};
        check_q("abort_evt_t", ev_q, exp_q);
        exp_q.delete();
        check_q("abort_done_t", dn_q, exp_q);
        check_int("abort_busy_cycles", busy_n, 12);

        // Full burst from index 0 after abort
        window(1'b0, 30, 0, -1);
        check_full_a("after_abort");

        // Asynchronous reset between edges, mid-burst
        window(1'b0, 10, 0, -1);
        check_int("pre_reset_busy", int'(busy_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset_a", {evt_a, 8'(idx_a), almost_a, last_a, busy_a, done_a}, 13'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ev_n = 0; bz_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (evt_a) ev_n++;
            if (busy_a) bz_n++;
        end
        check_int("post_reset_evts", ev_n, 0);
        check_int("post_reset_busy", bz_n, 0);

        // start and abort together in IDLE
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        ev_n = 0; bz_n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (evt_a) ev_n++;
            if (busy_a) bz_n++;
        end
        check_int("start_abort_evts", ev_n, 0);
        check_int("start_abort_busy", bz_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spec_evt_generator.md
# spec_evt_generator

Programmable event-burst generator: on a start request it emits a burst of exactly MAX_COUNT single-cycle event strobes, spaced PERIOD clock cycles apart. Each strobe carries its index plus almost-last and last flags. It is the source side of the event-counting path in the peripheral FPGA: it drives strobe sequences, such as bit or word strobes, into downstream event counters. Those counters must see the same wrap point the generator announces.

## Interface
Parameters:
- MAX_COUNT, default 6: events per burst; must be ≥ 2.
- PERIOD, default 4: cycles between consecutive events, and from start acceptance to the first event; must be ≥ 1.

Ports:
- clk_in, input, 1: single clock; all logic on rising edge.
- rst_n_in, input, 1: reset, asynchronous, active-low.
- start_in, input, 1: burst request; sampled only in IDLE.
- abort_in, input, 1: terminate the burst in progress.
- evt_out, output, 1: event strobe, one cycle wide.
- index_out, output, $clog2(MAX_COUNT): index of the current event, 0..MAX_COUNT-1.
- almost_out, output, 1: high with evt_out when index_out == MAX_COUNT-2.
- last_out, output, 1: high with evt_out when index_out == MAX_COUNT-1.
- busy_out, output, 1: burst in progress.
- done_out, output, 1: one-cycle pulse after a burst completes normally.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- FSM states:
  - IDLE → RUN: start_in=1 and abort_in=0; load the period timer to PERIOD-1 and clear the event index.
  - RUN → RUN: timer reaches 0 with index < MAX_COUNT-1; emit an event, increment the index, reload the timer.
  - RUN → DONE: timer reaches 0 with index == MAX_COUNT-1; emit the last event.
  - RUN → IDLE: abort_in=1.
  - DONE → IDLE: unconditional after one cycle; done_out=1 in that cycle.
- Output values by state:
  - busy_out = 1 while in RUN; 0 in IDLE and DONE.
  - index_out holds the last emitted index between strobes and is 0 in IDLE.
  - almost_out and last_out are 0 whenever evt_out is 0.
- Boundary rules:
  - start_in outside IDLE is ignored; no queuing.
  - start_in during the done_out cycle is accepted, because the FSM is already returning to IDLE.
  - abort_in has priority over event emission: if abort_in is sampled high on the same edge the timer expires, no event is emitted.
  - Abort produces no done_out and clears index_out.
  - abort_in in IDLE or DONE has no effect, and done_out is not suppressed.
  - start_in and abort_in high together in IDLE: stay in IDLE.
  - Index arithmetic is unsigned and never exceeds MAX_COUNT-1; the index wraps to 0 only via IDLE.
  - The period timer is $clog2(PERIOD) bits, minimum 1 bit. PERIOD=1 gives events on consecutive cycles.
  - rst_n_in low at any time clears all state and outputs immediately. After deassertion the block waits in IDLE for a new start_in.

## Timing
- Cycle numbering: t0 is the edge that samples start_in in IDLE.
- busy_out rises after t0.
- Event k (k = 0..MAX_COUNT-1) is visible in the cycle after edge t0 + (k+1)·PERIOD.
- last_out coincides with event MAX_COUNT-1.
- done_out is high in the cycle after the last event; busy_out is low in that cycle.
- Burst length is MAX_COUNT·PERIOD + 1 cycles from t0 to the done_out cycle.
- Abort sampled at edge ta: evt_out and busy_out are low in the cycle after ta.

## Structure
- Package spec_evt_pkg holds:
  - The state enum (IDLE, RUN, DONE) as typedef evt_gen_state_t.
  - A shared function returning the index width, so generator and counters size identically.
- Sub-module spec_period_timer holds the reloadable down-counter:
  - Inputs: load, enable.
  - Output: expire, asserted when the count is 0 while enabled.
  - Parameter: PERIOD.
- The top level holds the FSM, the index register and the output registers.

## Test plan
- MAX_COUNT=6, PERIOD=4, start at t0:
  - evt_out after edges t0+4, 8, 12, 16, 20, 24, with index 0..5.
  - almost_out only at t0+20 (index 4); last_out only at t0+24.
  - done_out after t0+25; busy_out high from t0+1 through t0+24.
- PERIOD=1, MAX_COUNT=2: start at t0 → events after t0+1 and t0+2 (last), done_out after t0+3.
- start_in pulsed every cycle during a burst → exactly 6 events and one done_out. start_in held in the done_out cycle → the next burst's first event 4 cycles later.
- abort_in at the edge where event 2 would fire:
  - Only events 0 and 1 are seen; no done_out; busy_out and index_out are 0 next cycle.
  - A new start then yields a full 6-event burst starting at index 0.
- rst_n_in asserted asynchronously mid-burst (between edges) → all outputs 0 immediately. After release, no events until start_in.
- start_in and abort_in high together in IDLE → busy_out stays 0 and no events.
